line_buf_arbiter: RTL and testbench

Two-master arbiter for the single-port line-buffer RAM shared by the UART command handler and the command processor. Each master sees a req/gnt access port with one-cycle read latency. The arbiter drives the RAM's address, data and write-enable. It uses round-robin ownership with a burst cap, so neither side can starve the other.

---
 rtl/line_buf_pkg.sv | 12 +
 rtl/line_buf_arbiter.sv | 79 +++++++
 tb/tb_line_buf_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared line-buffer widths, arbiter state encoding and log2 helper.
package line_buf_pkg;
  localparam int LB_WIDTH = 8;
  localparam int LB_AW = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN0 = 2'd1, S_OWN1 = 2'd2} state_t;
  function automatic int lb_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/line_buf_arbiter.sv
// line_buf_arbiter: round-robin, burst-capped two-master arbiter for the line-buffer RAM.
module line_buf_arbiter
  import line_buf_pkg::*;
#(
  parameter int WIDTH = LB_WIDTH,
  parameter int AW = LB_AW,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic [AW-1:0]    m0_addr,
  input  logic [WIDTH-1:0] m0_din,
  input  logic             m0_we,
  output logic             m0_gnt,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_rvalid,
  input  logic             m1_req,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_din,
  input  logic             m1_we,
  output logic             m1_gnt,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_rvalid,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_dout
);
  localparam int CW = lb_log2(MAX_BURST);
  state_t r_state;
  logic r_gnt0, r_gnt1, r_last, r_rd_pend, r_rd_who;
  logic [CW-1:0] r_cnt;
  logic w_acc0, w_acc1, w_cap, w_take0, w_take1;
  always_comb begin
    w_acc0 = m0_req & r_gnt0;
    w_acc1 = m1_req & r_gnt1;
    w_cap = r_cnt == CW'(MAX_BURST - 1);
    // from IDLE ties go to the master that is not last; from the other OWN state on release or burst cap
    w_take0 = m0_req & (r_state == S_IDLE ? (~m1_req | r_last) : r_state == S_OWN1 & (~m1_req | w_cap));
    w_take1 = m1_req & (r_state == S_IDLE ? (~m0_req | ~r_last) : r_state == S_OWN0 & (~m0_req | w_cap));
    mem_we = w_acc0 ? m0_we : w_acc1 & m1_we;
    mem_addr = w_acc0 ? m0_addr : w_acc1 ? m1_addr : '0;
    mem_din = w_acc0 ? m0_din : w_acc1 ? m1_din : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_last <= 1'b1;
      r_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_rd_who <= 1'b0;
    end else begin
      r_rd_pend <= (w_acc0 | w_acc1) & ~mem_we;
      r_rd_who <= w_acc1;
      if (w_take0 | w_take1) begin
        r_state <= w_take0 ? S_OWN0 : S_OWN1;
        r_gnt0 <= w_take0;
        r_gnt1 <= w_take1;
        r_last <= w_take1;
        r_cnt <= '0;
      end else if (r_state != S_IDLE && !(r_gnt0 ? m0_req : m1_req)) begin
        r_state <= S_IDLE;
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
      end else if ((w_acc0 & m1_req) | (w_acc1 & m0_req)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign m0_gnt = r_gnt0;
  assign m1_gnt = r_gnt1;
  assign m0_rvalid = r_rd_pend & ~r_rd_who;
  assign m1_rvalid = r_rd_pend & r_rd_who;
  assign m0_rdata = m0_rvalid ? mem_dout : '0;
  assign m1_rdata = m1_rvalid ? mem_dout : '0;
endmodule

// File: tb/tb_line_buf_arbiter.sv
// tb_line_buf_arbiter: directed scenario checks of the line-buffer arbiter against a behavioural RAM.
module tb_line_buf_arbiter;
  logic clk, rst;
  logic m0_req, m0_we, m0_gnt, m0_rvalid, m1_req, m1_we, m1_gnt, m1_rvalid, mem_we;
  logic [7:0] m0_addr, m0_din, m0_rdata, m1_addr, m1_din, m1_rdata, mem_addr, mem_din, mem_dout;
  logic [7:0] mem [256];
  int checks = 0, errors = 0, acc0 = 0, we_cnt = 0, a0, w0;

  line_buf_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
    if (m0_req & m0_gnt) acc0 <= acc0 + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin
        errors++; $display("FAIL reset_hold[%0d]: got %b want 000", i, {m0_gnt, m1_gnt, mem_we});
      end
    end
    rst = 0;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL reset_first_tie: got %b want 10", {m0_gnt, m1_gnt});
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL reset_to_idle: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
  endtask

  task automatic test_single;
    w0 = we_cnt;
    m1_addr = 8'h80; m1_din = 8'h41; m1_we = 1; m1_req = 1;
    @(negedge clk); #1;
    checks++;
    if ({m1_gnt, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 8'h80, 8'h41}) begin
      errors++; $display("FAIL single_write: got %h want %h", {m1_gnt, mem_we, mem_addr, mem_din}, {1'b1, 1'b1, 8'h80, 8'h41});
    end
    @(negedge clk); #1;
    m1_we = 0;
    #1;
    checks++;
    if ({mem_we, mem_addr} !== {1'b0, 8'h80}) begin
      errors++; $display("FAIL single_read_issue: got %h want %h", {mem_we, mem_addr}, {1'b0, 8'h80});
    end
    @(negedge clk); #1;
    checks++;
    if ({m1_rvalid, m1_rdata, m0_rvalid, m0_rdata} !== {1'b1, 8'h41, 1'b0, 8'h00}) begin
      errors++; $display("FAIL single_rdata: got %h want %h", {m1_rvalid, m1_rdata, m0_rvalid, m0_rdata}, {1'b1, 8'h41, 1'b0, 8'h00});
    end
    m1_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({m1_rvalid, m1_gnt} !== 2'b00 || we_cnt - w0 !== 1) begin
      errors++; $display("FAIL single_done: got rv/gnt %b writes %0d want 00 and 1", {m1_rvalid, m1_gnt}, we_cnt - w0);
    end
  endtask

  task automatic test_tie;
    rst = 1;
    @(negedge clk); #1;
    rst = 0; m0_we = 0; m1_we = 0; m0_addr = 8'h01; m1_addr = 8'h02; m0_req = 1; m1_req = 1;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL tie_first: got %b want 10", {m0_gnt, m1_gnt});
    end
    m0_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL tie_handover: got %b want 01", {m0_gnt, m1_gnt});
    end
    m1_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL tie_idle: got %b want 00", {m0_gnt, m1_gnt});
    end
    m0_req = 1; m1_req = 1;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL tie_round_robin: got %b want 10", {m0_gnt, m1_gnt});
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_burst;
    m0_we = 1; m0_addr = 8'h05; m0_din = 8'h24; m0_req = 1;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL burst_grant: got %b want 10", {m0_gnt, m1_gnt});
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        a0 = acc0; m1_we = 0; m1_addr = 8'h05; m1_req = 1;
      end
      m0_we = (i != 15);
      m0_addr = (i == 15) ? 8'h05 : 8'(16 + i);
      m0_din = 8'(i);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
        errors++; $display("FAIL burst_hold[%0d]: got %b want 10", i, {m0_gnt, m1_gnt});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL burst_release: got %b want 01", {m0_gnt, m1_gnt});
    end
    checks++;
    if (acc0 - a0 !== 16) begin
      errors++; $display("FAIL burst_count: got %0d want 16", acc0 - a0);
    end
    checks++;
    if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 8'h24, 1'b0}) begin
      errors++; $display("FAIL read_handover: got %h want %h", {m0_rvalid, m0_rdata, m1_rvalid}, {1'b1, 8'h24, 1'b0});
    end
    @(negedge clk); #1;
    checks++;
    if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 8'h24, 1'b0}) begin
      errors++; $display("FAIL burst_m1_read: got %h want %h", {m1_rvalid, m1_rdata, m0_rvalid}, {1'b1, 8'h24, 1'b0});
    end
    m1_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL burst_regrant: got %b want 10", {m0_gnt, m1_gnt});
    end
    m0_req = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid;
    m1_we = 0; m1_addr = 8'h80; m1_req = 1;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL mid_grant: got %b want 01", {m0_gnt, m1_gnt});
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_addr, mem_din, m0_rdata, m1_rdata} !== 37'd0) begin
        errors++; $display("FAIL mid_reset[%0d]: got %h want 0", i, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_addr, mem_din, m0_rdata, m1_rdata});
      end
    end
    rst = 0; m1_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({m0_gnt, m1_gnt, m1_rvalid} !== 3'b000) begin
      errors++; $display("FAIL mid_after: got %b want 000", {m0_gnt, m1_gnt, m1_rvalid});
    end
  endtask

  initial begin
    rst = 1; m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_din = 0; m1_din = 0;
    test_reset;
    test_single;
    test_tie;
    test_burst;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
